fp_round_pack: RTL

- Post-multiply stage that sits directly downstream of the fixed/float multiplier datapath.
- Accepts the multiplier's unrounded result: sign, biased exponent, 24-bit normalized significand, and guard/round/sticky bits.
- Applies the selected IEEE-754 rounding mode, renormalizes on rounding carry, resolves overflow, underflow and special operands, and packs a single-precision word.
- Multi-cycle FSM with valid/ready handshake on both sides.

---
 rtl/fp_round_pack.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/fp_round_pack.sv
`default_nettype none
// ============================================================================
// Module      : fp_round_pack
// Description : Post-multiply rounding stage. Takes the unrounded multiplier
//               result, applies the selected IEEE-754 rounding mode,
//               renormalizes on rounding carry, resolves overflow, underflow
//               and special operands, and packs a single-precision word.
//               Multi-cycle FSM with valid/ready handshake on both sides.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_round_pack #(
  parameter int          EXP_W = 10,
  parameter logic [31:0] QNAN  = 32'h7FC0_0000
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic             sign_i,
  input  logic [EXP_W-1:0] exp_i,
  input  logic [23:0]      mant_i,
  input  logic             guard_i,
  input  logic             round_i,
  input  logic             sticky_i,
  input  logic             is_nan_i,
  input  logic             is_inf_i,
  input  logic             is_zero_i,
  input  logic [1:0]       rm_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [31:0]      y_o,
  output logic             overflow_o,
  output logic             underflow_o,
  output logic             inexact_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ROUND = 3'd1,
    S_NORM  = 3'd2,
    S_PACK  = 3'd3,
    S_HOLD  = 3'd4
  } state_t;

  localparam logic [1:0] c_rm_rne = 2'b00;
  localparam logic [1:0] c_rm_rtz = 2'b01;
  localparam logic [1:0] c_rm_rup = 2'b10;

  // Exponent is held one bit wider than the input so the carry increment
  // can never wrap a large positive exponent into a negative one.
  localparam logic signed [EXP_W:0] c_exp_ovf = (EXP_W+1)'(255);
  localparam logic signed [EXP_W:0] c_exp_unf = '0;
  localparam logic signed [EXP_W:0] c_exp_one = (EXP_W+1)'(1);

  state_t                  state_q, state_d;
  logic                    sign_q;
  logic signed [EXP_W:0]   exp_q;
  logic [24:0]             m_q;
  logic                    g_q, r_q, s_q;
  logic                    inx_q;
  logic                    nan_q, inf_q, zero_q;
  logic [1:0]              rm_q;
  logic                    out_valid_q;
  logic [31:0]             y_q;
  logic                    ovf_q, unf_q, inxo_q;

  logic                    w_inx;
  logic                    w_inc;
  logic [31:0]             y_d;
  logic                    ovf_d, unf_d, inxo_d;

  assign in_ready_o  = (state_q == S_IDLE);
  assign out_valid_o = out_valid_q;
  assign y_o         = y_q;
  assign overflow_o  = ovf_q;
  assign underflow_o = unf_q;
  assign inexact_o   = inxo_q;

  // State register; reset in any state returns to IDLE and aborts the operation.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic: one pass through the pipeline, then wait for the consumer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (in_valid_i) state_d = S_ROUND;
      S_ROUND: state_d = S_NORM;
      S_NORM:  state_d = S_PACK;
      S_PACK:  state_d = S_HOLD;
      S_HOLD:  if (out_ready_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Rounding increment from the latched guard/round/sticky bits and mode.
  always_comb begin
    w_inx = g_q | r_q | s_q;
    case (rm_q)
      c_rm_rne: w_inc = g_q & (r_q | s_q | m_q[0]);
      c_rm_rtz: w_inc = 1'b0;
      c_rm_rup: w_inc = ~sign_q & w_inx;
      default:  w_inc = sign_q & w_inx;
    endcase
  end

  // Result selection in priority order: NaN, Inf, zero, overflow, underflow, normal.
  always_comb begin
    y_d    = {sign_q, exp_q[7:0], m_q[22:0]};
    ovf_d  = 1'b0;
    unf_d  = 1'b0;
    inxo_d = inx_q;
    if (nan_q) begin
      y_d    = QNAN;
      inxo_d = 1'b0;
    end else if (inf_q) begin
      y_d    = {sign_q, 8'hFF, 23'h0};
      inxo_d = 1'b0;
    end else if (zero_q) begin
      y_d    = {sign_q, 31'h0};
      inxo_d = 1'b0;
    end else if (exp_q >= c_exp_ovf) begin
      ovf_d  = 1'b1;
      inxo_d = 1'b1;
      case (rm_q)
        c_rm_rne: y_d = {sign_q, 8'hFF, 23'h0};
        c_rm_rtz: y_d = {sign_q, 8'hFE, 23'h7FFFFF};
        c_rm_rup: y_d = sign_q ? {1'b1, 8'hFE, 23'h7FFFFF} : {1'b0, 8'hFF, 23'h0};
        default:  y_d = sign_q ? {1'b1, 8'hFF, 23'h0} : {1'b0, 8'hFE, 23'h7FFFFF};
      endcase
    end else if (exp_q <= c_exp_unf) begin
      y_d    = {sign_q, 31'h0};
      unf_d  = 1'b1;
      inxo_d = 1'b1;
    end
  end

  // Datapath: latch operand, round, renormalize, register packed result.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sign_q      <= 1'b0;
      exp_q       <= '0;
      m_q         <= '0;
      g_q         <= 1'b0;
      r_q         <= 1'b0;
      s_q         <= 1'b0;
      inx_q       <= 1'b0;
      nan_q       <= 1'b0;
      inf_q       <= 1'b0;
      zero_q      <= 1'b0;
      rm_q        <= 2'b00;
      out_valid_q <= 1'b0;
      y_q         <= '0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
      inxo_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid_i) begin
            sign_q <= sign_i;
            exp_q  <= {exp_i[EXP_W-1], exp_i};
            m_q    <= {1'b0, mant_i};
            g_q    <= guard_i;
            r_q    <= round_i;
            s_q    <= sticky_i;
            nan_q  <= is_nan_i;
            inf_q  <= is_inf_i;
            zero_q <= is_zero_i;
            rm_q   <= rm_i;
          end
        end
        S_ROUND: begin
          inx_q <= w_inx;
          m_q   <= m_q + {24'h0, w_inc};
        end
        S_NORM: begin
          if (m_q[24]) begin
            m_q   <= m_q >> 1;
            exp_q <= exp_q + c_exp_one;
          end
        end
        S_PACK: begin
          y_q         <= y_d;
          ovf_q       <= ovf_d;
          unf_q       <= unf_d;
          inxo_q      <= inxo_d;
          out_valid_q <= 1'b1;
        end
        S_HOLD: begin
          if (out_ready_i) out_valid_q <= 1'b0;
        end
        default: out_valid_q <= 1'b0;
      endcase
    end
  end

endmodule
`default_nettype wire
